// File: rtl/pwm_peripheral.sv
// 16-pin PWM/static output stage driven by SPI control registers; one shared prescaled 8-bit PWM.
// Define PWM_DUTY_SHADOW_EN to latch the duty cycle only at period start (glitch-free updates).
module pwm_peripheral #(
    parameter int unsigned CLK_DIV = 13,
    parameter int unsigned DIV_W   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  en_reg_out_7_0,
    input  logic [7:0]  en_reg_out_15_8,
    input  logic [7:0]  en_reg_pwm_7_0,
    input  logic [7:0]  en_reg_pwm_15_8,
    input  logic [7:0]  pwm_duty_cycle,
    output logic [15:0] pwm_out,
    output logic        period_start
);

    if (CLK_DIV < 1 || (64'd1 << DIV_W) < 64'(CLK_DIV)) begin : g_bad_param
        $error("pwm_peripheral: CLK_DIV must be >= 1 and fit in DIV_W bits");
    end

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [7:0]       pwm_cnt_q, pwm_cnt_d;
    logic [15:0]      pwm_out_q, pwm_out_d;
    logic             period_start_q, period_start_d;
    logic             tick;
    logic             wrap;
    logic [7:0]       duty_eff;
    logic             pwm_level;
    logic [15:0]      en_out;
    logic [15:0]      en_pwm;

    always_comb begin
        tick           = (div_cnt_q == DIV_LAST);
        wrap           = tick & (pwm_cnt_q == 8'hFF);
        div_cnt_d      = tick ? '0 : div_cnt_q + DIV_W'(1);
        pwm_cnt_d      = tick ? pwm_cnt_q + 8'd1 : pwm_cnt_q;
        period_start_d = wrap;
    end

`ifdef PWM_DUTY_SHADOW_EN
    logic [7:0] duty_eff_q, duty_eff_d;

    // Loaded on the same edge pwm_cnt wraps to 0, so each period uses one duty value.
    always_comb begin
        duty_eff_d = wrap ? pwm_duty_cycle : duty_eff_q;
        duty_eff   = duty_eff_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_eff_q <= '0;
        end else begin
            duty_eff_q <= duty_eff_d;
        end
    end
`else
    always_comb begin
        duty_eff = pwm_duty_cycle;
    end
`endif

    // Full-scale duty is forced high so 0xFF never drops for the last count step.
    always_comb begin
        pwm_level = (duty_eff == 8'hFF) | (pwm_cnt_q < duty_eff);
        en_out    = {en_reg_out_15_8, en_reg_out_7_0};
        en_pwm    = {en_reg_pwm_15_8, en_reg_pwm_7_0};
        pwm_out_d = en_out & (~en_pwm | {16{pwm_level}});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q      <= '0;
            pwm_cnt_q      <= '0;
            pwm_out_q      <= '0;
            period_start_q <= 1'b0;
        end else begin
            div_cnt_q      <= div_cnt_d;
            pwm_cnt_q      <= pwm_cnt_d;
            pwm_out_q      <= pwm_out_d;
            period_start_q <= period_start_d;
        end
    end

    assign pwm_out      = pwm_out_q;
    assign period_start = period_start_q;

endmodule

// File: tb/tb_pwm_peripheral.sv
// Self-checking bench for pwm_peripheral (CLK_DIV=13, 3328-clk period): vector table plus
// hand-written sequences for period timing, duty extremes, shadowed duty update and async reset.
module tb_pwm_peripheral;

    localparam int PERIOD = 3328;
    localparam int BOUND  = 5000;

    logic        clk;
    logic        rst_n;
    logic [7:0]  en_reg_out_7_0;
    logic [7:0]  en_reg_out_15_8;
    logic [7:0]  en_reg_pwm_7_0;
    logic [7:0]  en_reg_pwm_15_8;
    logic [7:0]  pwm_duty_cycle;
    logic [15:0] pwm_out;
    logic        period_start;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [15:0] en_out;
        logic [15:0] en_pwm;
        logic [7:0]  duty;
        logic [15:0] exp_out;
    } vec_t;

    vec_t vecs [10];

    pwm_peripheral #(.CLK_DIV(13), .DIV_W(8)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .en_reg_out_7_0  (en_reg_out_7_0),
        .en_reg_out_15_8 (en_reg_out_15_8),
        .en_reg_pwm_7_0  (en_reg_pwm_7_0),
        .en_reg_pwm_15_8 (en_reg_pwm_15_8),
        .pwm_duty_cycle  (pwm_duty_cycle),
        .pwm_out         (pwm_out),
        .period_start    (period_start)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic sample();
        @(posedge clk);
        #1;
    endtask

    task automatic set_en(input logic [15:0] eo, input logic [15:0] ep);
        en_reg_out_15_8 = eo[15:8];
        en_reg_out_7_0  = eo[7:0];
        en_reg_pwm_15_8 = ep[15:8];
        en_reg_pwm_7_0  = ep[7:0];
    endtask

    // Samples until period_start is seen; n = samples taken including the pulse sample.
    task automatic wait_ps(input string name, output int n);
        n = 0;
        do begin
            sample();
            n++;
        end while (period_start !== 1'b1 && n < BOUND);
        check({name, "_seen"}, 32'(period_start), 32'd1);
    endtask

    // Counts consecutive samples where pin 0 equals val; the first differing sample is consumed.
    task automatic count_run(input string name, input logic val, output int n);
        n = 0;
        forever begin
            sample();
            if (pwm_out[0] !== val || n >= BOUND) break;
            n++;
        end
        check({name, "_bounded"}, 32'(n < BOUND), 32'd1);
    endtask

    function automatic logic [15:0] model_out(input logic [15:0] eo, input logic [15:0] ep,
                                              input logic [7:0] duty);
        return eo & (~ep | {16{duty == 8'hFF}});
    endfunction

    initial begin
        int n, hi, lo;
        logic [15:0] prev_eo, prev_ep;

        vecs[0] = '{16'h0000, 16'hFFFF, 8'h00, 16'h0000};
        vecs[1] = '{16'hFF00, 16'h0000, 8'h00, 16'hFF00};
        vecs[2] = '{16'h00FF, 16'h0F0F, 8'h00, 16'h00F0};
        vecs[3] = '{16'hFFFF, 16'hA5A5, 8'h00, 16'h5A5A};
        vecs[4] = '{16'h1234, 16'h0000, 8'h00, 16'h1234};
        vecs[5] = '{16'hFFFF, 16'hA5A5, 8'hFF, 16'hFFFF};
        vecs[6] = '{16'h0000, 16'hFFFF, 8'hFF, 16'h0000};
        vecs[7] = '{16'hFF00, 16'h0000, 8'hFF, 16'hFF00};
        vecs[8] = '{16'h8001, 16'h8000, 8'hFF, 16'h8001};
        vecs[9] = '{16'h00FF, 16'h00FF, 8'hFF, 16'h00FF};

        rst_n = 1'b0;
        set_en(16'h0000, 16'h0000);
        pwm_duty_cycle = 8'h00;
        #12;
        check("reset_pwm_out", 32'(pwm_out), 32'h0);
        check("reset_period_start", 32'(period_start), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Period timing from reset release
        wait_ps("first_ps", n);
        check("first_ps_delay", 32'(n), 32'(PERIOD));
        sample();
        check("ps_one_clk", 32'(period_start), 32'd0);
        check("all_regs_zero_out", 32'(pwm_out), 32'h0);
        wait_ps("second_ps", n);
        check("ps_interval", 32'(n + 1), 32'(PERIOD));

        // 50% duty on pin 0
        set_en(16'h0001, 16'h0001);
        pwm_duty_cycle = 8'h80;
        wait_ps("d80_ps", n);
        check("d80_low_at_ps", 32'(pwm_out), 32'h0);
        count_run("d80_high", 1'b1, hi);
        check("d80_high_time", 32'(hi), 32'd1664);
        count_run("d80_low", 1'b0, lo);
        check("d80_low_time", 32'(lo + 1), 32'd1664);
        check("d80_other_pins", 32'(pwm_out[15:1]), 32'h0);

        // Duty extremes over two full periods
        pwm_duty_cycle = 8'h00;
        wait_ps("d00_ps", n);
        hi = 0;
        for (int i = 0; i < 2 * PERIOD; i++) begin
            sample();
            if (pwm_out[0]) hi++;
        end
        check("d00_never_high", 32'(hi), 32'd0);
        pwm_duty_cycle = 8'hFF;
        wait_ps("dff_ps", n);
        lo = 0;
        for (int i = 0; i < 2 * PERIOD; i++) begin
            sample();
            if (!pwm_out[0]) lo++;
        end
        check("dff_never_low", 32'(lo), 32'd0);

        // Enable vectors: pwm_out follows exactly one clk after the write
        prev_eo = 16'h0001;
        prev_ep = 16'h0001;
        for (int i = 0; i < 10; i++) begin
            if (i == 0 || vecs[i].duty != vecs[i-1].duty) begin
                pwm_duty_cycle = vecs[i].duty;
                wait_ps($sformatf("vec%0d_ps", i), n);
                sample();
            end
            set_en(vecs[i].en_out, vecs[i].en_pwm);
            #1;
            check($sformatf("vec%0d_hold", i), 32'(pwm_out),
                  32'(model_out(prev_eo, prev_ep, vecs[i].duty)));
            sample();
            check($sformatf("vec%0d_out", i), 32'(pwm_out), 32'(vecs[i].exp_out));
            prev_eo = vecs[i].en_out;
            prev_ep = vecs[i].en_pwm;
        end

        // Duty 0x40 -> 0xC0 written when pwm_cnt reaches 0x20
        set_en(16'h0001, 16'h0001);
        pwm_duty_cycle = 8'h40;
        wait_ps("sh_ps0", n);
        wait_ps("sh_ps1", n);
        hi = 0;
        for (int i = 0; i < 416; i++) begin
            sample();
            if (pwm_out[0]) hi++;
        end
        check("sh_pre_write_high", 32'(hi), 32'd416);
        pwm_duty_cycle = 8'hC0;
        count_run("sh_cur", 1'b1, n);
`ifdef PWM_DUTY_SHADOW_EN
        check("sh_cur_period_high", 32'(hi + n), 32'd832);
`else
        check("sh_cur_period_high", 32'(hi + n), 32'd2496);
`endif
        wait_ps("sh_ps2", n);
        count_run("sh_next", 1'b1, hi);
        check("sh_next_period_high", 32'(hi), 32'd2496);

        // Asynchronous reset mid-period
        set_en(16'hFFFF, 16'h0000);
        sample();
        check("pre_rst_all_high", 32'(pwm_out), 32'hFFFF);
        repeat (500) sample();
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_out", 32'(pwm_out), 32'h0);
        check("async_rst_ps", 32'(period_start), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        sample();
        check("post_rst_out", 32'(pwm_out), 32'hFFFF);
        wait_ps("post_rst_ps", n);
        check("post_rst_ps_delay", 32'(n + 1), 32'(PERIOD));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
